clk_div_monitor: RTL

Receiving-end checker for divided clocks generated by the team's fixed odd/even clock dividers, such as the divide-by-5 50%-duty generator.
- Samples the divided clock on the source clock and measures period and high time in source-clock cycles.
- Flags period and duty errors against the expected ratio, and reports lock.
- Sits beside each divider instance as a built-in self-check and feeds status to the test/debug logic.

---
 rtl/clk_mon_pkg.sv | 21 ++
 rtl/clk_edge_sync.sv | 32 +++
 rtl/clk_div_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Provides the FSM state enum and the allowed high-time window helpers.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS      = 2'd2
    } state_t;

    // Shortest acceptable high time for a divider of ratio p.
    function automatic int unsigned hi_min(input int unsigned p);
        return p >> 1;
    endfunction

    // Longest acceptable high time; odd ratios may land on either half.
    function automatic int unsigned hi_max(input int unsigned p);
        return (p + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchronizer plus one delay flop and edge detector.
// Ports: clk, rst_n (sync, active-low), d (async in) -> lvl, rise, fall.
module clk_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock, flags errors, reports lock.
// Ports: clk, rst_n, en, clr_err, div_in -> period_out, high_out, meas_valid,
//        locked, err_period, err_duty, timeout.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned EXP_PERIOD = 5,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_err,
    input  logic             div_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_duty,
    output logic             timeout
);

    localparam int unsigned GW = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(hi_min(EXP_PERIOD));
    localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(hi_max(EXP_PERIOD));
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0]    LOCK_MX = GW'(LOCK_N);

    if (EXP_PERIOD < 2) begin : g_bad_ratio
        $error("EXP_PERIOD must be at least 2");
    end
    if (TIMEOUT <= EXP_PERIOD) begin : g_bad_timeout
        $error("TIMEOUT must exceed EXP_PERIOD");
    end

    // Synchronized view of the divided clock
    logic lvl_unused;
    logic rise;
    logic fall;

    clk_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (div_in),
        .lvl   (lvl_unused),
        .rise  (rise),
        .fall  (fall)
    );

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_cap_q;
    logic             fall_seen_q;
    logic [GW-1:0]    good_cnt_q;

    // FSM control decode
    logic start_meas;
    logic end_meas;
    logic run;
    logic cap_fall;
    logic to_hit;
    logic drop_lock;

    // Per-period check results
    logic [CNT_W-1:0] hi_eff;
    logic             period_ok;
    logic             duty_ok;
    logic             set_err_p;
    logic             set_err_d;
    logic [GW-1:0]    good_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      state_d = WAIT_RISE;
                WAIT_RISE: if (rise) state_d = MEAS;
                MEAS:      if (!rise && cnt_q == TO_CNT) state_d = WAIT_RISE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        start_meas = 1'b0;
        end_meas   = 1'b0;
        run        = 1'b0;
        cap_fall   = 1'b0;
        to_hit     = 1'b0;
        unique case (state_q)
            WAIT_RISE: start_meas = en & rise;
            MEAS: begin
                if (en) begin
                    if (rise) begin
                        end_meas = 1'b1;
                    end else begin
                        run      = 1'b1;
                        cap_fall = fall;
                        to_hit   = (cnt_q == TO_CNT);
                    end
                end
            end
            default: ;
        endcase
        drop_lock = ~en | to_hit | (state_q == IDLE);
    end

    // A period with no observed fall has a stale capture; treat it as all-high.
    assign hi_eff    = fall_seen_q ? hi_cap_q : cnt_q;
    assign period_ok = (cnt_q == EXP_P);
    assign duty_ok   = (hi_eff >= HI_MIN) && (hi_eff <= HI_MAX);
    assign set_err_p = end_meas & ~period_ok;
    assign set_err_d = end_meas & ~duty_ok;
    assign good_nxt  = (good_cnt_q == LOCK_MX) ? LOCK_MX : good_cnt_q + 1'b1;

    // Measurement datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            fall_seen_q <= 1'b0;
            period_out  <= '0;
            high_out    <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= end_meas;
            timeout    <= to_hit;
            if (start_meas) begin
                cnt_q       <= CNT_ONE;
                fall_seen_q <= 1'b0;
            end else if (end_meas) begin
                period_out  <= cnt_q;
                high_out    <= hi_eff;
                cnt_q       <= CNT_ONE;
                fall_seen_q <= 1'b0;
            end else if (run) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (cap_fall) begin
                    hi_cap_q    <= cnt_q;
                    fall_seen_q <= 1'b1;
                end
            end
        end
    end

    // Sticky errors: a new error in the clear cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_period <= 1'b0;
            err_duty   <= 1'b0;
        end else begin
            err_period <= set_err_p | (err_period & ~clr_err);
            err_duty   <= set_err_d | (err_duty & ~clr_err);
        end
    end

    // Lock tracking over consecutive good periods
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            locked     <= 1'b0;
        end else if (drop_lock) begin
            good_cnt_q <= '0;
            locked     <= 1'b0;
        end else if (end_meas) begin
            if (period_ok && duty_ok) begin
                good_cnt_q <= good_nxt;
                locked     <= (good_nxt == LOCK_MX);
            end else begin
                good_cnt_q <= '0;
                locked     <= 1'b0;
            end
        end
    end

endmodule
